gpio_serial_loader: RTL and testbench

Upstream driver for the GPIO configuration chain. It captures a parallel configuration image for `NUM_GPIO` pads and shifts it serially, MSB first, into the daisy-chained GPIO control blocks. It then issues one load strobe so every block latches its shifted word. It sits in the management domain between the housekeeping registers and the first GPIO control block's `serial_data_in` / `serial_clock` / `serial_load` inputs.

---
 rtl/gpio_serial_loader.sv | 114 +++++++++++
 tb/tb_gpio_serial_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// Upstream driver for the GPIO configuration chain: captures a parallel image,
// shifts it MSB first into the daisy-chained pad control blocks, then strobes load.
module gpio_serial_loader #(
    parameter int NUM_GPIO      = 4,
    parameter int PAD_CTRL_BITS = 13
) (
    input  logic                              serial_clock,
    input  logic                              resetn,
    input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] cfg_data,
    input  logic                              xfer_start,
    output logic                              busy,
    output logic                              done,
    output logic                              chain_clock,
    output logic                              chain_data,
    output logic                              chain_load
);

    localparam int TOTAL_BITS = NUM_GPIO * PAD_CTRL_BITS;
    localparam int COUNT_W    = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
    localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(TOTAL_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        GAP,
        LOAD
    } state_t;

    state_t                state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [TOTAL_BITS-1:0] shadow_q, shadow_d;

    logic busy_q, done_q, chain_clock_q, chain_data_q, chain_load_q;
    logic busy_d, done_d, chain_clock_d, chain_data_d, chain_load_d;

    // Output flops decode the current state, so every pin trails its state by one cycle.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d       = state_q;
        count_d       = count_q;
        shadow_d      = shadow_q;
        busy_d        = (state_q != IDLE);
        done_d        = chain_load_q;
        chain_clock_d = 1'b0;
        chain_data_d  = 1'b0;
        chain_load_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (xfer_start) begin
                    shadow_d = cfg_data;
                    count_d  = '0;
                    state_d  = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                chain_data_d = shadow_q[LAST_BIT - count_q];
                state_d      = SHIFT_HI;
            end
            SHIFT_HI: begin
                chain_clock_d = 1'b1;
                chain_data_d  = chain_data_q;
                if (count_q == LAST_BIT) begin
                    state_d = GAP;
                end else begin
                    count_d = count_q + COUNT_W'(1);
                    state_d = SHIFT_LO;
                end
            end
            GAP: begin
                state_d = LOAD;
            end
            LOAD: begin
                chain_load_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge serial_clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            count_q       <= '0;
            // NOTE: the shadow image is reset as well, so an aborted transfer leaves no stale image behind.
            shadow_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            chain_clock_q <= 1'b0;
            chain_data_q  <= 1'b0;
            chain_load_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from before the edge.
            state_q       <= state_d;
            count_q       <= count_d;
            shadow_q      <= shadow_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            chain_clock_q <= chain_clock_d;
            chain_data_q  <= chain_data_d;
            chain_load_q  <= chain_load_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign chain_clock = chain_clock_q;
    assign chain_data  = chain_data_q;
    assign chain_load  = chain_load_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: a transfer-level model queues expected
// images and cycle timing, a negedge monitor compares the pins and a downstream chain model.
`timescale 1ns/1ps
module tb_gpio_serial_loader;

    localparam int NG  = 4;
    localparam int PB  = 13;
    localparam int B   = NG * PB;
    localparam int LAT = 2 * B + 3;

    logic          serial_clock = 1'b0;
    logic          resetn       = 1'b1;
    logic [B-1:0]  cfg_data     = '0;
    logic          xfer_start   = 1'b0;
    logic          busy, done, chain_clock, chain_data, chain_load;

    logic [PB-1:0] cfg1   = '0;
    logic          start1 = 1'b0;
    logic          busy1, done1, clk1, data1, load1;

    always #5 serial_clock = ~serial_clock;

    gpio_serial_loader #(.NUM_GPIO(NG), .PAD_CTRL_BITS(PB)) dut (
        .serial_clock(serial_clock),
        .resetn      (resetn),
        .cfg_data    (cfg_data),
        .xfer_start  (xfer_start),
        .busy        (busy),
        .done        (done),
        .chain_clock (chain_clock),
        .chain_data  (chain_data),
        .chain_load  (chain_load)
    );

    gpio_serial_loader #(.NUM_GPIO(1), .PAD_CTRL_BITS(PB)) dut1 (
        .serial_clock(serial_clock),
        .resetn      (resetn),
        .cfg_data    (cfg1),
        .xfer_start  (start1),
        .busy        (busy1),
        .done        (done1),
        .chain_clock (clk1),
        .chain_data  (data1),
        .chain_load  (load1)
    );

    int cyc       = 0;
    int n_checks  = 0;
    int n_fail    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Downstream chain blocks: shift on chain_clock rise, serial out re-timed on its fall.
    logic [PB-1:0] blk_sr   [NG] = '{default: '0};
    logic [PB-1:0] blk_word [NG] = '{default: '0};
    logic [NG-1:0] blk_out       = '0;

    always @(posedge chain_clock) begin
        blk_sr[0] <= {blk_sr[0][PB-2:0], chain_data};
        for (int k = 1; k < NG; k++) blk_sr[k] <= {blk_sr[k][PB-2:0], blk_out[k-1]};
    end

    always @(negedge chain_clock) begin
        for (int k = 0; k < NG; k++) blk_out[k] <= blk_sr[k][PB-1];
    end

    always @(posedge chain_load) begin
        for (int k = 0; k < NG; k++) blk_word[k] <= blk_sr[k];
    end

    // Transfer-level reference: a start is taken when the loader is free, and it is
    // free again LAT edges after the last accepted start.
    typedef struct {
        logic [B-1:0] img;
        int           acc;
    } xfer_t;

    xfer_t exp_q[$];
    int    free_edge = 0;
    int    accepts   = 0;

    always @(posedge serial_clock) begin
        cyc++;
        if (!resetn) begin
            free_edge = cyc + 1;
        end else if (xfer_start && cyc >= free_edge) begin
            exp_q.push_back('{img: cfg_data, acc: cyc});
            free_edge = cyc + LAT;
            accepts++;
        end
    end

    // Monitor: pin values for cycle cyc, derived from the head transfer's age d.
    logic [B-1:0] stream     = '0;
    int           nbits      = 0;
    logic         prev_cc    = 1'b0;
    int           done_count = 0;
    int           load_count = 0;

    always @(negedge serial_clock) begin : monitor
        logic         eb, ed, ecc, ecd, el;
        int           d;
        logic [B-1:0] im;
        if (!resetn) begin
            exp_q.delete();
            nbits   = 0;
            prev_cc = 1'b0;
            check("outputs_in_reset", 64'({busy, done, chain_clock, chain_data, chain_load}), 64'(0));
        end else begin
            eb = 1'b0; ed = 1'b0; ecc = 1'b0; ecd = 1'b0; el = 1'b0;
            d  = -1;
            im = '0;
            if (exp_q.size() != 0) begin
                d   = cyc - exp_q[0].acc;
                im  = exp_q[0].img;
                eb  = (d >= 1 && d <= 2 * B + 2);
                ecc = (d >= 2 && d <= 2 * B && d % 2 == 0);
                if (d >= 1 && d <= 2 * B) ecd = im[B - 1 - (d - 1) / 2];
                el  = (d == 2 * B + 2);
                ed  = (d == LAT);
            end
            check("busy",        64'(busy),        64'(eb));
            check("chain_clock", 64'(chain_clock), 64'(ecc));
            check("chain_data",  64'(chain_data),  64'(ecd));
            check("chain_load",  64'(chain_load),  64'(el));
            check("done",        64'(done),        64'(ed));

            if (chain_clock && !prev_cc) begin
                stream = {stream[B-2:0], chain_data};
                nbits++;
            end
            prev_cc = chain_clock;

            if (chain_load) begin
                load_count++;
                check("load_clock_overlap", 64'(chain_clock), 64'(0));
                if (exp_q.size() != 0) begin
                    check("bits_shifted", 64'(nbits), 64'(B));
                    check("stream", 64'(stream), 64'(im));
                    for (int k = 0; k < NG; k++)
                        check("chain_word", 64'(blk_word[k]), 64'(im[k*PB +: PB]));
                end
                nbits = 0;
            end

            if (done && exp_q.size() != 0) begin
                done_count++;
                void'(exp_q.pop_front());
            end else if (exp_q.size() != 0 && d > LAT) begin
                check("done_timeout", 64'(d), 64'(LAT));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic start_xfer(input logic [B-1:0] img, output int acc);
        @(negedge serial_clock);
        cfg_data   = img;
        xfer_start = 1'b1;
        acc        = cyc + 1;
        @(negedge serial_clock);
        xfer_start = 1'b0;
        cfg_data   = B'({$urandom(), $urandom()});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * LAT) begin
            @(negedge serial_clock);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(negedge serial_clock);
    endtask

    task automatic run_single();
        int   exp_seq[13];
        int   got[$];
        int   a, load_d, done_d;
        logic pc;
        exp_seq = '{1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1};
        load_d  = -1;
        done_d  = -1;
        pc      = 1'b0;
        @(negedge serial_clock);
        cfg1   = 13'h1A5B;
        start1 = 1'b1;
        a      = cyc + 1;
        @(negedge serial_clock);
        start1 = 1'b0;
        cfg1   = 13'h0000;
        for (int n = 0; n < 40 && done_d < 0; n++) begin
            if (clk1 && !pc) got.push_back(int'(data1));
            pc = clk1;
            if (load1 && load_d < 0) load_d = cyc - a;
            if (done1) done_d = cyc - a;
            @(negedge serial_clock);
        end
        check("single_bits", 64'(got.size()), 64'(13));
        for (int j = 0; j < 13 && j < got.size(); j++)
            check("single_bit", 64'(got[j]), 64'(exp_seq[j]));
        check("single_load_cycle", 64'(load_d), 64'(28));
        check("single_done_cycle", 64'(done_d), 64'(29));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int a, base, loads_before;
        #1 resetn = 1'b0;
        #1;
        check("reset_outputs_dut",  64'({busy, done, chain_clock, chain_data, chain_load}), 64'(0));
        check("reset_outputs_dut1", 64'({busy1, done1, clk1, data1, load1}), 64'(0));
        repeat (2) @(negedge serial_clock);
        resetn = 1'b1;

        run_single();

        // Idle stability: the monitor expects quiet pins while nothing is queued.
        repeat (100) @(negedge serial_clock);
        check("idle_busy", 64'(busy), 64'(0));

        // Chain model: word k must land in block k.
        start_xfer({13'h0A55, 13'h1FFF, 13'h0402, 13'h0001}, a);
        drain();

        // Starts during a transfer are dropped and the captured image is kept.
        base = done_count;
        start_xfer(B'({$urandom(), $urandom()}), a);
        while (cyc < a + 4) @(negedge serial_clock);
        cfg_data   = B'({$urandom(), $urandom()});
        xfer_start = 1'b1;
        @(negedge serial_clock);
        xfer_start = 1'b0;
        while (cyc < a + 49) @(negedge serial_clock);
        cfg_data   = B'({$urandom(), $urandom()});
        xfer_start = 1'b1;
        @(negedge serial_clock);
        xfer_start = 1'b0;
        drain();
        check("ignored_starts_done_count", 64'(done_count - base), 64'(1));

        // Reset in cycle 40 aborts the transfer without a load pulse.
        start_xfer(B'({$urandom(), $urandom()}), a);
        while (cyc < a + 40) @(negedge serial_clock);
        loads_before = load_count;
        #2 resetn = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({busy, done, chain_clock, chain_data, chain_load}), 64'(0));
        @(negedge serial_clock);
        @(negedge serial_clock);
        resetn = 1'b1;
        repeat (5) @(negedge serial_clock);
        check("no_load_after_reset", 64'(load_count - loads_before), 64'(0));
        start_xfer(B'({$urandom(), $urandom()}), a);
        drain();

        // Back-to-back with start held high and the image changing every cycle.
        base = done_count;
        a    = accepts;
        @(negedge serial_clock);
        xfer_start = 1'b1;
        cfg_data   = B'({$urandom(), $urandom()});
        for (int n = 0; n < 4 * LAT && accepts < a + 3; n++) begin
            @(negedge serial_clock);
            cfg_data = B'({$urandom(), $urandom()});
        end
        xfer_start = 1'b0;
        drain();
        check("b2b_done_count", 64'(done_count - base), 64'(3));

        // Random images with random idle gaps.
        for (int t = 0; t < 4; t++) begin
            start_xfer(B'({$urandom(), $urandom()}), a);
            drain();
            repeat ($urandom_range(0, 5)) @(negedge serial_clock);
        end

        check("final_busy", 64'(busy), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
